// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the 68030 bus-cycle controller.
package bus_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} bus_state_t;

   localparam logic [1:0] PORT8  = 2'b01;
   localparam logic [1:0] PORT16 = 2'b10;
   localparam logic [1:0] PORT32 = 2'b11;

   localparam logic [2:0] FC_CPU_SPACE = 3'b111;
   localparam logic [3:0] IACK_A_CPU   = 4'hF;

   typedef struct packed {
      logic [3:0] wst;
      logic [1:0] port;
      logic       ext;
   } region_attr_t;
endpackage

// File: rtl/region_decoder.sv
// Combinational window decode of A[31:28]: per-region hits, lowest-index winner
// and the winner's attributes. The boot overlay collapses all data space onto the ROM.
module region_decoder
   import bus_ctrl_pkg::*;
#(
   parameter int                         NUM_REGIONS = 4,
   parameter int                         SEL_W       = 2,
   parameter logic [4*NUM_REGIONS-1:0]   REGION_BASE = {4'hF, 4'h8, 4'h0, 4'hE},
   parameter logic [4*NUM_REGIONS-1:0]   REGION_WAIT = 16'h2010,
   parameter logic [2*NUM_REGIONS-1:0]   REGION_PORT = 8'b01_11_11_01,
   parameter logic [NUM_REGIONS-1:0]     REGION_EXT  = 4'b0100,
   parameter int                         ROM_REGION  = 0
) (
   input  logic [3:0]             i_a_hi,
   input  logic [2:0]             i_fc,
   input  logic                   i_boot,
   output logic [NUM_REGIONS-1:0] o_hit,
   output logic [SEL_W-1:0]       o_sel,
   output logic                   o_mapped,
   output region_attr_t           o_attr
);
   logic w_cpu_space;
   assign w_cpu_space = (i_fc == FC_CPU_SPACE);

   for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_hit
      assign o_hit[g] = ~w_cpu_space &
                        (i_boot ? (g == ROM_REGION) : (i_a_hi == REGION_BASE[4*g +: 4]));
   end

   assign o_mapped = |o_hit;

   always_comb begin
      o_sel  = '0;
      o_attr = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--)
         if (o_hit[i]) o_sel = SEL_W'(i);
      for (int i = 0; i < NUM_REGIONS; i++)
         if (o_sel == SEL_W'(i))
            o_attr = '{wst: REGION_WAIT[4*i +: 4], port: REGION_PORT[2*i +: 2], ext: REGION_EXT[i]};
   end
endmodule

// File: rtl/bus_cycle_controller.sv
// 68030 bus-cycle controller: region chip selects, DSACK/AVEC/BERR termination,
// bus-timeout watchdog and boot ROM overlay.
module bus_cycle_controller
   import bus_ctrl_pkg::*;
#(
   parameter int                         NUM_REGIONS    = 4,
   parameter logic [4*NUM_REGIONS-1:0]   REGION_BASE    = {4'hF, 4'h8, 4'h0, 4'hE},
   parameter logic [4*NUM_REGIONS-1:0]   REGION_WAIT    = 16'h2010,
   parameter logic [2*NUM_REGIONS-1:0]   REGION_PORT    = 8'b01_11_11_01,
   parameter logic [NUM_REGIONS-1:0]     REGION_EXT     = 4'b0100,
   parameter int                         ROM_REGION     = 0,
   parameter int                         BOOT_CYCLES    = 8,
   parameter int                         TIMEOUT_CYCLES = 255
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [3:0]               i_a_hi,
   input  logic [2:0]               i_iack_lvl,
   input  logic [2:0]               i_fc,
   input  logic [3:0]               i_a_cpu,
   input  logic                     i_as_n,
   input  logic                     i_ds_n,
   input  logic [2*NUM_REGIONS-1:0] i_ext_dsack_n,
   input  logic [6:0]               i_vec_lvl_mask,
   output logic [NUM_REGIONS-1:0]   o_cs_n,
   output logic [1:0]               o_dsack_n,
   output logic                     o_berr_n,
   output logic                     o_avec_n,
   output logic                     o_boot
);
   localparam int SEL_W  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
   localparam int BOOT_W = $clog2(BOOT_CYCLES + 2);

   logic [NUM_REGIONS-1:0] w_hit;
   logic [SEL_W-1:0]       w_sel;
   logic                   w_mapped;
   region_attr_t           w_attr;

   bus_state_t       r_state, w_state_nxt;
   logic [3:0]       r_wcnt;
   logic [7:0]       r_tcnt;
   logic [SEL_W-1:0] r_sel;
   logic [1:0]       r_port;
   logic             r_ext, r_mapped, r_iack, r_avec_ok;
   logic [1:0]       r_dsack_n, w_dsack_nxt;
   logic             r_berr_n, w_berr_nxt;
   logic             r_avec_n, w_avec_nxt;
   logic             r_as_q, r_boot;
   logic [BOOT_W-1:0] r_bcnt;

   logic       w_iack, w_avec_ok, w_term, w_tout, w_as_rise;
   logic [7:0] w_lvl_mask;
   logic [1:0] w_ext_pair;

   region_decoder #(
      .NUM_REGIONS(NUM_REGIONS), .SEL_W(SEL_W), .REGION_BASE(REGION_BASE),
      .REGION_WAIT(REGION_WAIT), .REGION_PORT(REGION_PORT), .REGION_EXT(REGION_EXT),
      .ROM_REGION(ROM_REGION)
   ) u_dec (
      .i_a_hi(i_a_hi), .i_fc(i_fc), .i_boot(r_boot),
      .o_hit(w_hit), .o_sel(w_sel), .o_mapped(w_mapped), .o_attr(w_attr)
   );

   // 8-bit internal ports also need DS_n; reset forces every select off.
   for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_cs
      localparam bit DS_QUAL = (REGION_PORT[2*g +: 2] == PORT8) && !REGION_EXT[g];
      assign o_cs_n[g] = ~(w_hit[g] & (w_sel == SEL_W'(g)) & ~i_as_n & ~i_rst &
                           (~i_ds_n | ~DS_QUAL));
   end

   assign w_iack     = (i_fc == FC_CPU_SPACE) & (i_a_cpu == IACK_A_CPU);
   assign w_lvl_mask = {i_vec_lvl_mask, 1'b0};
   assign w_avec_ok  = w_lvl_mask[i_iack_lvl];
   assign w_as_rise  = i_as_n & ~r_as_q;

   always_comb begin
      w_ext_pair = 2'b11;
      for (int i = 0; i < NUM_REGIONS; i++)
         if (r_sel == SEL_W'(i)) w_ext_pair = i_ext_dsack_n[2*i +: 2];
   end

   // Internal regions terminate on the edge where the wait count reaches zero.
   assign w_term = r_iack ? r_avec_ok :
                   (r_mapped & (r_ext ? (w_ext_pair != 2'b11) : (r_wcnt <= 4'd1)));
   assign w_tout = (r_tcnt == 8'(TIMEOUT_CYCLES));

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (!i_as_n) w_state_nxt = WAIT;
         WAIT:    if (i_as_n)       w_state_nxt = IDLE;
                  else if (w_term)  w_state_nxt = ACK;
                  else if (w_tout)  w_state_nxt = ERR;
         ACK,
         ERR:     if (i_as_n) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_dsack_nxt = r_dsack_n;
      w_berr_nxt  = r_berr_n;
      w_avec_nxt  = r_avec_n;
      case (r_state)
         WAIT:
            if (!i_as_n && w_term) begin
               if (r_iack) w_avec_nxt  = 1'b0;
               else        w_dsack_nxt = r_ext ? w_ext_pair : ~r_port;
            end else if (!i_as_n && w_tout) begin
               w_berr_nxt = 1'b0;
            end
         ACK,
         ERR:
            if (i_as_n) begin
               w_dsack_nxt = 2'b11;
               w_berr_nxt  = 1'b1;
               w_avec_nxt  = 1'b1;
            end
         default: begin
            w_dsack_nxt = 2'b11;
            w_berr_nxt  = 1'b1;
            w_avec_nxt  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_dsack_n <= 2'b11;
         r_berr_n  <= 1'b1;
         r_avec_n  <= 1'b1;
      end else begin
         r_dsack_n <= w_dsack_nxt;
         r_berr_n  <= w_berr_nxt;
         r_avec_n  <= w_avec_nxt;
      end

   // Cycle attributes are captured at AS_n fall so mid-cycle decode changes are ignored.
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_wcnt    <= '0;
         r_tcnt    <= '0;
         r_sel     <= '0;
         r_port    <= '0;
         r_ext     <= 1'b0;
         r_mapped  <= 1'b0;
         r_iack    <= 1'b0;
         r_avec_ok <= 1'b0;
      end else if (r_state == IDLE && !i_as_n) begin
         r_wcnt    <= w_attr.wst;
         r_tcnt    <= '0;
         r_sel     <= w_sel;
         r_port    <= w_attr.port;
         r_ext     <= w_attr.ext;
         r_mapped  <= w_mapped;
         r_iack    <= w_iack;
         r_avec_ok <= w_avec_ok;
      end else if (r_state == WAIT) begin
         if (r_wcnt != 4'd0)  r_wcnt <= r_wcnt - 4'd1;
         if (r_tcnt != 8'hFF) r_tcnt <= r_tcnt + 8'd1;
      end

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_as_q <= 1'b1;
         r_boot <= 1'b1;
         r_bcnt <= '0;
      end else begin
         r_as_q <= i_as_n;
         if (r_boot && w_as_rise) begin
            r_bcnt <= r_bcnt + 1'b1;
            if (r_bcnt == BOOT_W'(BOOT_CYCLES - 1)) r_boot <= 1'b0;
         end
      end

   assign o_dsack_n = r_dsack_n;
   assign o_berr_n  = r_berr_n;
   assign o_avec_n  = r_avec_n;
   assign o_boot    = r_boot;
endmodule

// File: tb/tb_bus_cycle_controller.sv
// Randomized bench for bus_cycle_controller against a cycle-level bus model.
module tb_bus_cycle_controller;
   localparam int          NR  = 4;
   localparam logic [15:0] RB  = {4'hF, 4'h8, 4'h0, 4'hE};
   localparam logic [15:0] RW  = 16'h2010;
   localparam logic [7:0]  RP  = 8'b01_11_11_01;
   localparam logic [3:0]  RE  = 4'b0100;
   localparam int          ROM = 0;
   localparam int          BC  = 8;
   localparam int          TO  = 255;

   logic            clk = 1'b0;
   logic            i_rst = 1'b1;
   logic [3:0]      i_a_hi = '0;
   logic [2:0]      i_iack_lvl = '0;
   logic [2:0]      i_fc = '0;
   logic [3:0]      i_a_cpu = '0;
   logic            i_as_n = 1'b1;
   logic            i_ds_n = 1'b1;
   logic [2*NR-1:0] i_ext_dsack_n = '1;
   logic [6:0]      i_vec_lvl_mask = '0;
   logic [NR-1:0]   o_cs_n;
   logic [1:0]      o_dsack_n;
   logic            o_berr_n, o_avec_n, o_boot;

   logic [15:0] v_rb = RB;
   logic [15:0] v_rw = RW;
   logic [7:0]  v_rp = RP;
   logic [3:0]  v_re = RE;

   int n_chk = 0;
   int n_bad = 0;
   bit m_boot = 1'b1;
   int m_bcnt = 0;

   always #5 clk = ~clk;

   bus_cycle_controller #(
      .NUM_REGIONS(NR), .REGION_BASE(RB), .REGION_WAIT(RW), .REGION_PORT(RP),
      .REGION_EXT(RE), .ROM_REGION(ROM), .BOOT_CYCLES(BC), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_a_hi(i_a_hi), .i_iack_lvl(i_iack_lvl), .i_fc(i_fc),
      .i_a_cpu(i_a_cpu), .i_as_n(i_as_n), .i_ds_n(i_ds_n), .i_ext_dsack_n(i_ext_dsack_n),
      .i_vec_lvl_mask(i_vec_lvl_mask), .o_cs_n(o_cs_n), .o_dsack_n(o_dsack_n),
      .o_berr_n(o_berr_n), .o_avec_n(o_avec_n), .o_boot(o_boot)
   );

   // Region the spec's decode rules pick, -1 when unmapped.
   function automatic int exp_region(logic [3:0] ahi, logic [2:0] fc, bit boot);
      if (fc == 3'b111) return -1;
      if (boot) return ROM;
      for (int i = 0; i < NR; i++) if (v_rb[4*i +: 4] == ahi) return i;
      return -1;
   endfunction

   function automatic logic [NR-1:0] exp_cs(int r, logic ds_n);
      logic [NR-1:0] cs = '1;
      if (r >= 0 && (!(v_rp[2*r +: 2] == 2'b01 && !v_re[r]) || !ds_n)) cs[r] = 1'b0;
      return cs;
   endfunction

   function automatic bit outs_idle();
      return (o_dsack_n === 2'b11) && (o_berr_n === 1'b1) && (o_avec_n === 1'b1);
   endfunction

   task automatic boot_step();
      if (m_boot) begin
         m_bcnt++;
         if (m_bcnt == BC) m_boot = 1'b0;
      end
   endtask

   // One complete bus cycle; edge 1 is the first posedge with AS_n low.
   task automatic access(input logic [3:0] ahi, input logic [2:0] fc, input logic [3:0] acpu,
                         input logic [2:0] lvl, input logic [6:0] mask, input int ext_d,
                         input logic [1:0] ext_p, input int hold, input string nm);
      int r, te, kind, w;
      logic [1:0] ed;
      logic [7:0] lm;
      bit early, held;
      r = exp_region(ahi, fc, m_boot);
      kind = 2; te = TO + 2; ed = 2'b11;
      lm = {mask, 1'b0};
      if (fc == 3'b111 && acpu == 4'hF) begin
         if (lm[lvl]) begin kind = 1; te = 2; end
      end else if (r >= 0) begin
         if (v_re[r]) begin
            if (ext_d + 1 <= TO + 2) begin
               kind = 0; ed = ext_p; te = (ext_d + 1 < 2) ? 2 : ext_d + 1;
            end
         end else begin
            w = int'(v_rw[4*r +: 4]);
            kind = 0; ed = ~v_rp[2*r +: 2]; te = 1 + ((w == 0) ? 1 : w);
         end
      end
      i_ext_dsack_n = (2*NR)'($urandom);
      if (r >= 0 && v_re[r]) i_ext_dsack_n[2*r +: 2] = 2'b11;
      i_a_hi = ahi; i_fc = fc; i_a_cpu = acpu; i_iack_lvl = lvl; i_vec_lvl_mask = mask;
      i_ds_n = 1'b1; i_as_n = 1'b0;
      #1;
      n_chk++;
      if (o_cs_n !== exp_cs(r, 1'b1)) begin
         n_bad++; $display("FAIL %s cs_ds_high: got=%b want=%b", nm, o_cs_n, exp_cs(r, 1'b1));
      end
      i_ds_n = 1'b0;
      #1;
      n_chk++;
      if (o_cs_n !== exp_cs(r, 1'b0)) begin
         n_bad++; $display("FAIL %s cs: got=%b want=%b", nm, o_cs_n, exp_cs(r, 1'b0));
      end
      early = 1'b0;
      for (int k = 1; k <= te; k++) begin
         @(posedge clk); #1;
         if (k < te && !outs_idle()) early = 1'b1;
         if (r >= 0 && v_re[r] && k == ext_d) i_ext_dsack_n[2*r +: 2] = ext_p;
      end
      n_chk++;
      if (early) begin
         n_bad++; $display("FAIL %s early_term: got=1 want=0 (edge %0d expected)", nm, te);
      end
      n_chk++;
      if (o_dsack_n !== ((kind == 0) ? ed : 2'b11)) begin
         n_bad++; $display("FAIL %s dsack: got=%b want=%b", nm, o_dsack_n, (kind == 0) ? ed : 2'b11);
      end
      n_chk++;
      if (o_avec_n !== ((kind == 1) ? 1'b0 : 1'b1)) begin
         n_bad++; $display("FAIL %s avec: got=%b want=%b", nm, o_avec_n, (kind == 1) ? 1'b0 : 1'b1);
      end
      n_chk++;
      if (o_berr_n !== ((kind == 2) ? 1'b0 : 1'b1)) begin
         n_bad++; $display("FAIL %s berr: got=%b want=%b", nm, o_berr_n, (kind == 2) ? 1'b0 : 1'b1);
      end
      held = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         if (o_dsack_n !== ((kind == 0) ? ed : 2'b11) || o_berr_n !== (kind != 2) ||
             o_avec_n !== (kind != 1)) held = 1'b0;
      end
      n_chk++;
      if (!held) begin
         n_bad++; $display("FAIL %s hold: got=0 want=1", nm);
      end
      i_as_n = 1'b1; i_ds_n = 1'b1; i_ext_dsack_n = '1;
      @(posedge clk); #1;
      boot_step();
      n_chk++;
      if (!outs_idle() || o_cs_n !== '1) begin
         n_bad++;
         $display("FAIL %s release: got=%b%b%b/%b want=11111/%b", nm, o_dsack_n, o_berr_n,
                  o_avec_n, o_cs_n, {NR{1'b1}});
      end
      n_chk++;
      if (o_boot !== m_boot) begin
         n_bad++; $display("FAIL %s boot: got=%b want=%b", nm, o_boot, m_boot);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (!outs_idle() || o_boot !== 1'b1 || o_cs_n !== '1) begin
         n_bad++; $display("FAIL reset: got=%b%b%b%b cs=%b want=11111 cs=1111",
                           o_dsack_n, o_berr_n, o_avec_n, o_boot, o_cs_n);
      end
      i_rst = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if (!outs_idle() || o_boot !== 1'b1) begin
         n_bad++; $display("FAIL reset_release: got=%b%b%b%b want=11111",
                           o_dsack_n, o_berr_n, o_avec_n, o_boot);
      end
   endtask

   task automatic test_boot();
      for (int i = 0; i < BC; i++)
         access(4'($urandom), 3'($urandom_range(0, 6)), 4'h0, 3'd0, 7'd0, 0, 2'b11,
                $urandom_range(0, 2), "boot_rom");
      access(4'h0, 3'd5, 4'h0, 3'd0, 7'd0, 0, 2'b11, 1, "post_boot_0");
   endtask

   task automatic test_internal();
      logic [3:0] bases [3];
      bases[0] = 4'hE; bases[1] = 4'h0; bases[2] = 4'hF;
      access(4'hF, 3'd6, 4'h0, 3'd0, 7'd0, 0, 2'b11, 0, "int_r3");
      for (int i = 0; i < 6; i++)
         access(bases[$urandom_range(0, 2)], 3'($urandom_range(1, 6)), 4'h0, 3'd0, 7'd0, 0,
                2'b11, $urandom_range(0, 3), "int_rand");
   endtask

   task automatic test_external();
      logic [1:0] pairs [3];
      pairs[0] = 2'b00; pairs[1] = 2'b01; pairs[2] = 2'b10;
      access(4'h8, 3'd5, 4'h0, 3'd0, 7'd0, 5, 2'b01, 1, "ext_d5");
      for (int i = 0; i < 4; i++)
         access(4'h8, 3'($urandom_range(1, 6)), 4'h0, 3'd0, 7'd0, $urandom_range(1, 30),
                pairs[$urandom_range(0, 2)], $urandom_range(0, 3), "ext_rand");
   endtask

   task automatic test_unmapped();
      access(4'h3, 3'd5, 4'h0, 3'd0, 7'd0, 0, 2'b11, 2, "unmapped");
      access(4'h0, 3'b111, 4'h2, 3'd0, 7'h7F, 0, 2'b11, 0, "cpu_space");
   endtask

   task automatic test_iack();
      logic [2:0] lvl;
      logic [6:0] mask;
      access(4'h0, 3'b111, 4'hF, 3'd5, 7'b0010000, 0, 2'b11, 1, "iack5_avec");
      for (int i = 0; i < 4; i++) begin
         lvl = 3'($urandom_range(1, 7));
         mask = 7'($urandom) | (7'd1 << (lvl - 3'd1));
         access(4'($urandom), 3'b111, 4'hF, lvl, mask, 0, 2'b11, $urandom_range(0, 2), "iack_rand");
      end
      access(4'h0, 3'b111, 4'hF, 3'd5, 7'b1101111, 0, 2'b11, 1, "iack5_berr");
   endtask

   task automatic test_term_vs_timeout();
      access(4'h8, 3'd1, 4'h0, 3'd0, 7'd0, TO + 1, 2'b10, 1, "term_at_timeout");
   endtask

   task automatic test_abort();
      bit quiet = 1'b1;
      i_a_hi = 4'hF; i_fc = 3'd5; i_ds_n = 1'b0; i_as_n = 1'b0;
      @(posedge clk); #1;
      i_as_n = 1'b1; i_ds_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (!outs_idle() || o_cs_n !== '1) quiet = 1'b0;
      end
      boot_step();
      n_chk++;
      if (!quiet) begin
         n_bad++; $display("FAIL abort: got=outputs_active want=idle");
      end
      access(4'h0, 3'd2, 4'h0, 3'd0, 7'd0, 0, 2'b11, 0, "after_abort");
   endtask

   task automatic test_reset_mid();
      int r;
      r = exp_region(4'h0, 3'd5, m_boot);
      i_ext_dsack_n = '1; i_a_hi = 4'h0; i_fc = 3'd5; i_ds_n = 1'b0; i_as_n = 1'b0;
      repeat (1 + ((v_rw[4*r +: 4] == 4'd0) ? 1 : int'(v_rw[4*r +: 4])))
         @(posedge clk);
      #1;
      n_chk++;
      if (o_dsack_n !== ~v_rp[2*r +: 2] || o_cs_n !== exp_cs(r, 1'b0)) begin
         n_bad++; $display("FAIL rst_ack_pre: got=%b/%b want=%b/%b", o_dsack_n, o_cs_n,
                           ~v_rp[2*r +: 2], exp_cs(r, 1'b0));
      end
      #2 i_rst = 1'b1;
      #1;
      n_chk++;
      if (!outs_idle() || o_cs_n !== '1 || o_boot !== 1'b1) begin
         n_bad++; $display("FAIL rst_in_ack: got=%b%b%b%b cs=%b want=11111 cs=1111",
                           o_dsack_n, o_berr_n, o_avec_n, o_boot, o_cs_n);
      end
      @(posedge clk); #1;
      i_as_n = 1'b1; i_ds_n = 1'b1; i_rst = 1'b0;
      m_boot = 1'b1; m_bcnt = 0;
      i_a_hi = 4'h2; i_fc = 3'b111; i_a_cpu = 4'hF; i_iack_lvl = 3'd3; i_vec_lvl_mask = 7'd0;
      i_as_n = 1'b0;
      repeat (TO + 2) @(posedge clk);
      #1;
      n_chk++;
      if (o_berr_n !== 1'b0) begin
         n_bad++; $display("FAIL rst_err_pre: got=%b want=0", o_berr_n);
      end
      #2 i_rst = 1'b1;
      #1;
      n_chk++;
      if (!outs_idle() || o_boot !== 1'b1) begin
         n_bad++; $display("FAIL rst_in_err: got=%b%b%b%b want=11111",
                           o_dsack_n, o_berr_n, o_avec_n, o_boot);
      end
      @(posedge clk); #1;
      i_as_n = 1'b1; i_rst = 1'b0;
      i_a_hi = 4'h5; i_fc = 3'd1; i_ds_n = 1'b0; i_as_n = 1'b0;
      repeat (20) @(posedge clk);
      #3 i_rst = 1'b1;
      #1;
      n_chk++;
      if (!outs_idle() || o_cs_n !== '1 || o_boot !== 1'b1) begin
         n_bad++; $display("FAIL rst_in_wait: got=%b%b%b%b cs=%b want=11111 cs=1111",
                           o_dsack_n, o_berr_n, o_avec_n, o_boot, o_cs_n);
      end
      @(posedge clk); #1;
      i_as_n = 1'b1; i_ds_n = 1'b1; i_rst = 1'b0;
      @(posedge clk); #1;
      access(4'h8, 3'd5, 4'h0, 3'd0, 7'd0, 0, 2'b11, 1, "rom_after_rst");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_boot();
      test_internal();
      test_external();
      test_unmapped();
      test_iack();
      test_term_vs_timeout();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
